// File: rtl/data_ram_ws_pkg.sv
// Shared constants for the wait-state data RAM: FSM encodings and lane geometry.
package data_ram_ws_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  // Width of one byte lane
  localparam int LANE_WIDTH = 8;

  // Wait counter width; covers WAIT_CYCLES up to 15
  localparam int CNT_WIDTH = 4;

  // Expand a byte-lane select vector into a bit mask
  function automatic logic [63:0] lane_mask(input logic [7:0] lanes);
    logic [63:0] mask;
    mask = '0;
    for (int i = 0; i < 8; i++) begin
      if (lanes[i]) mask[i*LANE_WIDTH +: LANE_WIDTH] = '1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/data_ram_array.sv
// Word-organised storage with per-byte-lane write enables, synchronous write
// and asynchronous read of the addressed word.
module data_ram_array
  import data_ram_ws_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH/8-1:0] wr_sel,
  input  logic [ADDR_WIDTH-1:0]   wr_index,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [ADDR_WIDTH-1:0]   rd_index,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  localparam int LANES = DATA_WIDTH / LANE_WIDTH;

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Byte-lane masked write of the addressed word
  // NOTE: storage has no reset branch; clearing a RAM would need one write per
  // word and would prevent mapping onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_sel[i]) begin
          mem[wr_index][i*LANE_WIDTH +: LANE_WIDTH] <= wr_data[i*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  assign rd_data = mem[rd_index];

endmodule

// File: rtl/data_ram_ws.sv
// Data RAM with programmable wait states behind a ce/ack handshake.
// A request is captured in IDLE, counted down in WAIT, and completed with a
// one-cycle ack in ACK; writes commit on the edge that ends ACK.
module data_ram_ws
  import data_ram_ws_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ce,
  input  logic                    we,
  input  logic [31:0]             addr,
  input  logic [DATA_WIDTH/8-1:0] sel,
  input  logic [DATA_WIDTH-1:0]   data_i,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic                    ack_o,
  output logic                    stall_o
);

  localparam int LANES = DATA_WIDTH / LANE_WIDTH;
  localparam logic [CNT_WIDTH-1:0] WAIT_LOAD = CNT_WIDTH'(WAIT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  logic [1:0]            state;
  logic [1:0]            next_state;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  cap_we;
  logic [ADDR_WIDTH-1:0] cap_index;
  logic [LANES-1:0]      cap_sel;
  logic [DATA_WIDTH-1:0] cap_data;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wr_en;

  // Byte offset and bits above the word index do not select storage
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:ADDR_WIDTH+2], addr[1:0]};

  // Next-state decode
  // NOTE: next_state is defaulted before the case so every path assigns it and
  // no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (ce) next_state = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACK;
      ST_WAIT: begin
        if (!ce)              next_state = ST_IDLE;
        else if (cnt == CNT_ONE) next_state = ST_ACK;
      end
      ST_ACK:  next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // State, wait counter and request capture with synchronous active-low reset
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cap_we    <= 1'b0;
      cap_index <= '0;
      cap_sel   <= '0;
      cap_data  <= '0;
    end else begin
      state <= next_state;
      case (state)
        ST_IDLE: begin
          if (ce) begin
            cap_we    <= we;
            cap_index <= addr[ADDR_WIDTH+1:2];
            cap_sel   <= sel;
            cap_data  <= data_i;
            cnt       <= WAIT_LOAD;
          end
        end
        ST_WAIT: cnt <= cnt - CNT_ONE;
        default: ;
      endcase
    end
  end

  assign ack_o   = (state == ST_ACK);
  assign stall_o = ce & ~ack_o;

  // A reset arriving in ACK must suppress the commit on that same edge
  assign wr_en = ack_o & cap_we & rst;

  // Read data: selected lanes of the captured word during a read ack, else 0
  always_comb begin
    data_o = '0;
    if (ack_o && !cap_we) begin
      for (int i = 0; i < LANES; i++) begin
        if (cap_sel[i]) data_o[i*LANE_WIDTH +: LANE_WIDTH] = rd_data[i*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  data_ram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk      (clk),
    .wr_en    (wr_en),
    .wr_sel   (cap_sel),
    .wr_index (cap_index),
    .wr_data  (cap_data),
    .rd_index (cap_index),
    .rd_data  (rd_data)
  );

endmodule
